// File: rtl/tdm_pkg.sv
// Shared constants and types for the TDM demultiplexer.
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int DW     = 7;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef logic [1:0] slot_t;

  localparam slot_t LAST_SLOT = slot_t'(NUM_CH - 1);

endpackage

// File: rtl/tdm_if.sv
// TinyTapeout tile pin bundle between the demux and whatever drives its pins.
interface tdm_if;

  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);

endinterface

// File: rtl/tdm_slot_ctrl.sv
// Frame-lock FSM: tracks the expected slot, flags sync errors and
// tells the top which channel register to write.
module tdm_slot_ctrl
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  input  logic  sync,
  output logic  wr_en,
  output slot_t wr_slot,
  output logic  locked,
  output logic  sync_err,
  output logic  frame_done
);

  state_e state_q, state_d;
  slot_t  exp_slot_q, exp_slot_d;
  logic   sync_err_q, sync_err_d;
  logic   frame_done_q, frame_done_d;

  // Next-state and write decode for each incoming sample.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
    state_d    = state_q;
    exp_slot_d = exp_slot_q;
    sync_err_d = sync_err_q;
    wr_en      = 1'b0;
    wr_slot    = '0;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            wr_en      = 1'b1;
            exp_slot_d = slot_t'(1);
            state_d    = LOCKED;
          end
        end
        LOCKED: begin
          if (sync) begin
            // A sync arriving early is a short frame: flag it and resync on it.
            if (exp_slot_q != '0) sync_err_d = 1'b1;
            wr_en      = 1'b1;
            exp_slot_d = slot_t'(1);
          end else if (exp_slot_q == '0) begin
            // Slot 0 without sync means the frame ran long; drop and re-hunt.
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end else begin
            wr_en      = 1'b1;
            wr_slot    = exp_slot_q;
            exp_slot_d = slot_t'(exp_slot_q + 2'd1);
          end
        end
        default: state_d = HUNT;
      endcase
    end

    frame_done_d = wr_en && (wr_slot == LAST_SLOT);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_n) begin
      state_q      <= HUNT;
      exp_slot_q   <= '0;
      sync_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_slot_q   <= exp_slot_d;
      sync_err_q   <= sync_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign sync_err   = sync_err_q;
  assign frame_done = frame_done_q;

endmodule

// File: rtl/tt_um_tdm_demux.sv
// TDM demultiplexer top: channel holding registers, freshness flags,
// readout mux and TinyTapeout pin mapping.
module tt_um_tdm_demux
  import tdm_pkg::*;
(
  input logic  clk,
  input logic  rst_n,
  tdm_if.slave pins
);

  logic          in_valid;
  logic          sync;
  logic [DW-1:0] din;
  slot_t         rd_sel;
  logic          rd_ack;

  assign din      = pins.ui_in[6:0];
  assign sync     = pins.ui_in[7];
  assign in_valid = pins.uio_in[0];
  assign rd_sel   = pins.uio_in[2:1];
  assign rd_ack   = pins.uio_in[3];

  logic  wr_en;
  slot_t wr_slot;
  logic  locked;
  logic  sync_err;
  logic  frame_done;

  tdm_slot_ctrl u_slot_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .sync       (sync),
    .wr_en      (wr_en),
    .wr_slot    (wr_slot),
    .locked     (locked),
    .sync_err   (sync_err),
    .frame_done (frame_done)
  );

  logic [DW-1:0]     ch_q [NUM_CH];
  logic [DW-1:0]     ch_d [NUM_CH];
  logic [NUM_CH-1:0] fresh_q, fresh_d;

  // Channel write and fresh-flag update; a write beats a same-cycle ack.
  always_comb begin
    ch_d    = ch_q;
    fresh_d = fresh_q;
    if (rd_ack) fresh_d[rd_sel] = 1'b0;
    if (wr_en) begin
      ch_d[wr_slot]    = din;
      fresh_d[wr_slot] = 1'b1;
    end
  end

  // Channel registers and fresh flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the channel registers are reset because reset must make uo_out read zero for every rd_sel.
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
      fresh_q <= '0;
    end else begin
      ch_q    <= ch_d;
      fresh_q <= fresh_d;
    end
  end

  assign pins.uo_out  = {fresh_q[rd_sel], ch_q[rd_sel]};
  assign pins.uio_out = {|fresh_q, frame_done, sync_err, locked, 4'b0000};
  assign pins.uio_oe  = 8'hF0;

  logic unused_ok;
  assign unused_ok = &{1'b0, pins.ena, pins.uio_in[7:4]};

endmodule

// File: tb/tb_tt_um_tdm_demux.sv
// Self-checking bench for tt_um_tdm_demux: directed frames from the test
// plan followed by random traffic, compared against a behavioural model.
module tb_tt_um_tdm_demux;

  logic clk;
  logic rst_n;

  tdm_if pins ();

  tt_um_tdm_demux dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pins  (pins.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] uo;
    logic [7:0] uio;
    int         seq;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   seq_no   = 0;

  // Behavioural model: what the receiver has captured so far.
  bit       m_locked;
  int       m_next;
  bit       m_err;
  bit       m_done;
  bit [6:0] m_ch [4];
  bit [3:0] m_fresh;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req, input int seq);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, seq, act, req);
    end
  endtask

  task automatic model_step(input bit rstn, input bit valid, input bit sync,
                            input bit [6:0] data, input bit [1:0] rsel, input bit ack);
    int wrote;
    if (!rstn) begin
      m_locked = 0; m_next = 0; m_err = 0; m_done = 0; m_fresh = '0;
      for (int i = 0; i < 4; i++) m_ch[i] = '0;
      return;
    end
    wrote = -1;
    if (valid) begin
      if (sync) begin
        if (m_locked && m_next != 0) m_err = 1;
        wrote    = 0;
        m_next   = 1;
        m_locked = 1;
      end else if (m_locked) begin
        if (m_next == 0) begin
          m_err    = 1;
          m_locked = 0;
        end else begin
          wrote  = m_next;
          m_next = (m_next + 1) % 4;
        end
      end
    end
    if (ack) m_fresh[rsel] = 0;
    m_done = (wrote == 3);
    if (wrote >= 0) begin
      m_ch[wrote]    = data;
      m_fresh[wrote] = 1;
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then advance.
  task automatic apply(input bit rstn, input bit valid, input bit sync,
                       input bit [6:0] data, input bit [1:0] rsel, input bit ack);
    exp_t e;
    pins.ena    = 1'b1;
    pins.ui_in  = {sync, data};
    pins.uio_in = {4'($urandom), ack, rsel, valid};
    rst_n       = rstn;
    model_step(rstn, valid, sync, data, rsel, ack);
    e.uo  = {m_fresh[rsel], m_ch[rsel]};
    e.uio = {|m_fresh, m_done, m_err, m_locked, 4'b0000};
    e.seq = seq_no++;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input bit [1:0] rsel);
    apply(1, 0, 0, 7'($urandom), rsel, 0);
  endtask

  task automatic do_reset();
    apply(0, 1, 1, 7'h5A, 0, 1);
    apply(0, 0, 0, 7'h00, 0, 0);
  endtask

  // Monitor: one expected record per clock edge, sampled just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("uo_out", pins.uo_out, e.uo, e.seq);
        check("uio_out", pins.uio_out, e.uio, e.seq);
        check("uio_oe", pins.uio_oe, 8'hF0, e.seq);
      end
    end
  end

  initial begin
    pins.ena = 1'b1; pins.ui_in = '0; pins.uio_in = '0; rst_n = 1'b0;

    // Basic frame, then sweep the readout select.
    do_reset();
    apply(1, 1, 1, 7'h11, 0, 0);
    apply(1, 1, 0, 7'h22, 0, 0);
    apply(1, 1, 0, 7'h33, 1, 0);
    apply(1, 1, 0, 7'h44, 2, 0);
    for (int i = 0; i < 4; i++) idle(2'(i));

    // Unsynced samples while hunting are ignored.
    do_reset();
    apply(1, 1, 0, 7'h55, 0, 0);
    apply(1, 1, 0, 7'h55, 1, 0);
    idle(0);
    apply(1, 1, 1, 7'h21, 0, 0);
    apply(1, 1, 0, 7'h32, 1, 0);

    // Short frame: early sync resyncs and flags the error.
    do_reset();
    apply(1, 1, 1, 7'h0A, 0, 0);
    apply(1, 1, 0, 7'h01, 0, 0);
    apply(1, 1, 0, 7'h02, 0, 0);
    apply(1, 1, 1, 7'h7F, 0, 0);
    apply(1, 1, 0, 7'h12, 1, 0);
    idle(1);

    // Missing sync after a full frame: sample dropped, lock lost.
    do_reset();
    apply(1, 1, 1, 7'h01, 0, 0);
    apply(1, 1, 0, 7'h02, 0, 0);
    apply(1, 1, 0, 7'h03, 0, 0);
    apply(1, 1, 0, 7'h04, 3, 0);
    apply(1, 1, 0, 7'h66, 0, 0);
    idle(0);
    apply(1, 1, 0, 7'h67, 1, 0);

    // Read-acknowledge, and ack colliding with a write to the same channel.
    do_reset();
    apply(1, 1, 1, 7'h10, 2, 0);
    apply(1, 1, 0, 7'h20, 2, 0);
    apply(1, 1, 0, 7'h30, 2, 0);
    apply(1, 1, 0, 7'h40, 2, 0);
    idle(2);
    apply(1, 0, 0, 7'h00, 2, 1);
    idle(2);
    apply(1, 1, 1, 7'h11, 2, 0);
    apply(1, 1, 0, 7'h22, 2, 0);
    apply(1, 1, 0, 7'h3C, 2, 1);
    idle(2);

    // Reset in the middle of a frame, then a clean restart.
    apply(1, 1, 1, 7'h45, 0, 0);
    apply(1, 1, 0, 7'h46, 1, 0);
    apply(0, 1, 0, 7'h47, 1, 1);
    idle(1);
    apply(1, 1, 1, 7'h48, 0, 0);
    apply(1, 1, 0, 7'h49, 1, 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      bit rstn, valid, sync, ack;
      rstn  = ($urandom_range(0, 199) != 0);
      valid = ($urandom_range(0, 3) != 0);
      sync  = ($urandom_range(0, 4) == 0);
      ack   = ($urandom_range(0, 3) == 0);
      apply(rstn, valid, sync, 7'($urandom), 2'($urandom), ack);
    end

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_um_tdm_demux.md
# tt_um_tdm_demux

Time-division demultiplexer for the TinyTapeout tile: the receive-side counterpart of the 7-bit select-mux block. It accepts a stream of 7-bit samples tagged with a frame-sync bit, locks onto the frame, steers each slot into one of four channel holding registers, and presents any channel on the dedicated outputs under external select. Per-channel freshness flags with read-acknowledge form a simple handshake to the downstream consumer.

## Interface
- NUM_CH, 4, channels per frame (fixed by the 2-bit select field)
- DW, 7, sample width in bits
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ena  in  1  tile enable; always 1 when powered, ignored
- ui_in  in  8  [6:0] sample data, [7] sync: marks slot 0 of a frame
- uio_in  in  8  [0] in_valid, [2:1] rd_sel, [3] rd_ack, [7:4] unused
- uo_out  out  8  [6:0] channel register selected by rd_sel, [7] fresh[rd_sel]
- uio_out  out  8  [3:0] 0, [4] locked, [5] sync_err (sticky), [6] frame_done pulse, [7] OR of all fresh flags
- uio_oe  out  8  constant 8'hF0

## Operation
- FSM states HUNT, LOCKED; 2-bit expected-slot counter exp_slot.
- HUNT: valid & !sync -> sample discarded. valid & sync -> write ch[0], exp_slot=1, go LOCKED.
- LOCKED, valid & !sync, exp_slot!=0 -> write ch[exp_slot], exp_slot+1 (wraps 3->0).
- LOCKED, valid & !sync, exp_slot==0 (missing sync, long frame) -> sample discarded, sync_err=1, go HUNT.
- LOCKED, valid & sync, exp_slot==0 -> normal frame start: write ch[0], exp_slot=1.
- LOCKED, valid & sync, exp_slot!=0 (short frame) -> sync_err=1, resync: write ch[0], exp_slot=1, stay LOCKED.
- !valid: no state change; gaps between samples of any length allowed.
- Each write sets fresh[ch]. rd_ack high in a cycle clears fresh[rd_sel]; simultaneous write to the same channel: set wins.
- frame_done: asserted for exactly one cycle after the write to slot NUM_CH-1.
- sync_err cleared only by reset. locked = (state==LOCKED).

## Timing
- All state updates on rising clk; inputs sampled on the edge.
- Write latency 1: sample on edge N visible on uo_out (if selected) from edge N onward, i.e. next cycle.
- uo_out is a combinational mux of registers by rd_sel: rd_sel change reflected same cycle.
- frame_done high during the cycle following the slot-3 write edge.
- Reset (rst_n low at an edge, including mid-frame): state=HUNT, exp_slot=0, all ch regs=0, fresh=0, sync_err=0, frame_done=0; uo_out=8'h00, uio_out=8'h00; uio_oe=8'hF0 always.
- rst_n low overrides any concurrent valid/rd_ack.

## Structure
- Package tdm_pkg: NUM_CH, DW, state enum {HUNT, LOCKED}, slot index type.
- Sub-module tdm_slot_ctrl: FSM, exp_slot counter, sync_err, frame_done; outputs write-enable and slot index. Top holds channel registers, fresh flags, readout mux, pin mapping.

## Test plan
- Reset then frame 0x11(sync),0x22,0x33,0x44 with valid each cycle -> ch0..3 = 0x11..0x44, locked=1, frame_done one pulse, fresh=4'hF, sync_err=0.
- Unsynced samples in HUNT (0x55, no sync) -> no writes, locked=0; then sync frame -> lock on first sync cycle.
- Short frame: sync,0x01,0x02 then sync 0x7F -> sync_err=1, ch0=0x7F, locked=1, exp_slot=1.
- Missing sync: full frame then 0x66 without sync -> sample dropped, sync_err=1, locked=0.
- rd_sel=2, rd_ack pulsed -> uo_out[7] 1->0; rd_ack coinciding with slot-2 write -> fresh[2] stays 1, uo_out[6:0] shows new value next cycle.
- Reset asserted mid-frame after slot 1 -> all outputs 0, HUNT; next sync restarts at ch0.
